// File: rtl/tx_pll_lock_pkg.sv
// Shared types and helpers for the TX PLL lock manager.
package tx_pll_lock_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_SETTLE,
        ST_READY,
        ST_RSTREQ
    } lock_state_e;

    // Width of the per-channel cycle counter: enough for the largest terminal count.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // Increment that sticks at max instead of wrapping.
    function automatic logic [63:0] sat_inc(input logic [63:0] v,
                                            input logic [63:0] max);
        return (v >= max) ? max : v + 64'd1;
    endfunction

endpackage

// File: rtl/tx_pll_lock_chan.sv
// One PLL channel: lock synchroniser, lock/settle/timeout FSM and loss counter.
module tx_pll_lock_chan
    import tx_pll_lock_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned SETTLE_CYCLES  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned RST_CYCLES     = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             lock,
    input  logic             clr_cnt,
    output logic             ready,
    output logic             loss_pulse,
    output logic [CNT_W-1:0] loss_cnt,
    output logic             pll_rst_n
);

    localparam int unsigned TW = cnt_width(SETTLE_CYCLES, TIMEOUT_CYCLES, RST_CYCLES);
    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
    localparam logic [63:0]   CNT_MAX      = (64'd1 << CNT_W) - 64'd1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    lock_state_e            state_q, state_d;
    logic [TW-1:0]          cnt_q, cnt_d;
    logic                   ready_q;
    logic                   loss_q;
    logic                   rst_n_q;
    logic [CNT_W-1:0]       loss_cnt_q;
    logic                   loss_evt;

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Multi-flop synchroniser for the asynchronous lock flag.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], lock};
    end

    // State and shared cycle counter registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_UNLOCKED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and cycle counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_UNLOCKED: begin
                if (lock_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_RSTREQ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            ST_SETTLE: begin
                if (!lock_s) begin
                    state_d = ST_UNLOCKED;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            ST_READY: begin
                if (!lock_s) begin
                    state_d = ST_UNLOCKED;
                    cnt_d   = '0;
                end
            end
            ST_RSTREQ: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_UNLOCKED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
                cnt_d   = '0;
            end
        endcase
    end

    // READY can only exit to UNLOCKED, so "UNLOCKED now, was READY last cycle"
    // marks exactly one cycle per lock loss.
    assign loss_evt = (state_q == ST_UNLOCKED) && ready_q;

    // Output flops load from the state register, one cycle behind the FSM.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ready_q    <= 1'b0;
            loss_q     <= 1'b0;
            rst_n_q    <= 1'b1;
            loss_cnt_q <= '0;
        end else begin
            ready_q <= (state_q == ST_READY);
            rst_n_q <= (state_q != ST_RSTREQ);
            loss_q  <= loss_evt;
            if (clr_cnt)
                loss_cnt_q <= loss_evt ? CNT_W'(1) : '0;
            else if (loss_evt)
                loss_cnt_q <= CNT_W'(sat_inc(64'(loss_cnt_q), CNT_MAX));
        end
    end

    assign ready      = ready_q;
    assign loss_pulse = loss_q;
    assign loss_cnt   = loss_cnt_q;
    assign pll_rst_n  = rst_n_q;

endmodule

// File: rtl/tx_pll_lock_mgr.sv
// Lock manager for a bank of TX PLLs: per-channel lock tracking plus ALL_READY.
module tx_pll_lock_mgr
    import tx_pll_lock_pkg::*;
#(
    parameter int unsigned N_PLL          = 2,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned SETTLE_CYCLES  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned RST_CYCLES     = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                   CLK,
    input  logic                   ARST_N,
    input  logic [N_PLL-1:0]       LOCK,
    input  logic                   CLR_CNT,
    output logic [N_PLL-1:0]       READY,
    output logic                   ALL_READY,
    output logic [N_PLL-1:0]       LOSS_PULSE,
    output logic [N_PLL*CNT_W-1:0] LOSS_CNT,
    output logic [N_PLL-1:0]       PLL_RST_N
);

    logic all_ready_q;

    for (genvar g = 0; g < N_PLL; g++) begin : gen_chan
        tx_pll_lock_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .SETTLE_CYCLES  (SETTLE_CYCLES),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .RST_CYCLES     (RST_CYCLES),
            .CNT_W          (CNT_W)
        ) u_chan (
            .clk        (CLK),
            .arst_n     (ARST_N),
            .lock       (LOCK[g]),
            .clr_cnt    (CLR_CNT),
            .ready      (READY[g]),
            .loss_pulse (LOSS_PULSE[g]),
            .loss_cnt   (LOSS_CNT[g*CNT_W +: CNT_W]),
            .pll_rst_n  (PLL_RST_N[g])
        );
    end

    // Registered AND of all per-channel ready flags.
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) all_ready_q <= 1'b0;
        else         all_ready_q <= &READY;
    end

    assign ALL_READY = all_ready_q;

endmodule
